// File: rtl/uart_loader.sv
// UART command loader: 'W' hi lo data writes one memory byte, 'R' hi lo reads one back.
// Every command gets exactly one reply byte: 'K' for a write, the read data, or '?' for an unknown command.
module uart_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 120000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  overrun
);
    localparam int unsigned      CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       CMD_WR    = 8'h57;
    localparam logic [7:0]       CMD_RD    = 8'h52;
    localparam logic [7:0]       REPLY_OK  = 8'h4B;
    localparam logic [7:0]       REPLY_ERR = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_wr_q, cmd_wr_d;
    logic [7:0]              addr_hi_q, addr_hi_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hold_first_q, hold_first_d;
    logic                    tx_start_q, tx_start_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]              mem_wdata_q, mem_wdata_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_re_q, mem_re_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    expired_c;

    assign expired_c = (cnt_q == CNT_LAST);

    // Next-state and next-output logic; the counter only advances while a command is half-received.
    always_comb begin
        state_d      = state_q;
        cmd_wr_d     = cmd_wr_q;
        addr_hi_d    = addr_hi_q;
        cnt_d        = '0;
        hold_first_d = 1'b0;
        tx_start_d   = 1'b0;
        tx_byte_d    = tx_byte_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        overrun_d    = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                        cmd_wr_d = (rx_byte == CMD_WR);
                        state_d  = S_ADDR_HI;
                    end else begin
                        tx_byte_d = REPLY_ERR;
                        state_d   = S_SEND;
                    end
                end
            end
            S_ADDR_HI: begin
                if (rx_valid) begin
                    addr_hi_d = rx_byte;
                    state_d   = S_ADDR_LO;
                end else if (expired_c) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADDR_LO: begin
                if (rx_valid) begin
                    mem_addr_d = ADDR_WIDTH'({addr_hi_q, rx_byte});
                    if (cmd_wr_q) begin
                        state_d = S_DATA;
                    end else begin
                        mem_re_d = 1'b1;
                        state_d  = S_RD_REQ;
                    end
                end else if (expired_c) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    mem_wdata_d = rx_byte;
                    mem_we_d    = 1'b1;
                    tx_byte_d   = REPLY_OK;
                    state_d     = S_SEND;
                end else if (expired_c) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // mem_re is high during RD_REQ, so read data is valid while in RD_WAIT.
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                tx_byte_d = mem_rdata;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start_d   = 1'b1;
                    hold_first_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!hold_first_q && !tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_valid && (state_q == S_RD_REQ || state_q == S_RD_WAIT ||
                         state_q == S_SEND   || state_q == S_HOLD)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_wr_q     <= 1'b0;
            addr_hi_q    <= '0;
            cnt_q        <= '0;
            hold_first_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_wr_q     <= cmd_wr_d;
            addr_hi_q    <= addr_hi_d;
            cnt_q        <= cnt_d;
            hold_first_q <= hold_first_d;
            tx_start_q   <= tx_start_d;
            tx_byte_q    <= tx_byte_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_byte   = tx_byte_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed command table, multi-cycle corner sequences,
// and random commands predicted by a transaction-level memory/reply model.
module tb_uart_loader;
    localparam int unsigned AW = 16;
    localparam int unsigned TO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tx_busy = 1'b0;
    logic          tx_start, mem_we, mem_re, busy, overrun;
    logic [7:0]    tx_byte, mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic [AW-1:0] mem_addr;

    uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event log of DUT strobes, sampled on the falling edge.
    int          we_n = 0, re_n = 0, tx_n = 0;
    logic [15:0] we_addr = '0, re_addr = '0;
    logic [7:0]  we_data = '0, tx_seen = '0;
    bit          both_seen = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin we_n++; we_addr = mem_addr; we_data = mem_wdata; end
        if (mem_re) begin re_n++; re_addr = mem_addr; end
        if (tx_start) begin tx_n++; tx_seen = tx_byte; end
        if (mem_we && mem_re) both_seen = 1'b1;
    end

    // UART transmitter: busy for tx_len cycles after each tx_start, or forced busy.
    int tx_len = 3;
    int tx_left = 0;
    bit tx_force = 1'b0;
    always @(negedge clk) begin
        if (tx_start) tx_left = tx_len;
        else if (tx_left > 0) tx_left--;
        tx_busy = tx_force || (tx_left > 0);
    end

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory device attached to the DUT.
    logic [7:0] bmem [int];
    always @(posedge clk) begin
        if (mem_we) bmem[int'(mem_addr)] = mem_wdata;
        if (mem_re) mem_rdata <= bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : dflt(mem_addr);
    end

    // Reference memory contents as implied by the commands the bench has issued.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, " returns idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_cmd(input string name, input int n, input logic [0:3][7:0] b,
                           input bit exp_we, input bit exp_re, input logic [15:0] exp_addr,
                           input logic [7:0] exp_wdata, input logic [7:0] exp_reply, input int gap);
        int we0, re0, tx0;
        we0 = we_n; re0 = re_n; tx0 = tx_n;
        for (int i = 0; i < n; i++) begin
            send_byte(b[i]);
            repeat (gap) @(negedge clk);
        end
        wait_idle(name);
        check({name, " we count"}, 32'(we_n - we0), 32'(exp_we));
        check({name, " re count"}, 32'(re_n - re0), 32'(exp_re));
        check({name, " tx count"}, 32'(tx_n - tx0), 32'd1);
        check({name, " reply"}, 32'(tx_seen), 32'(exp_reply));
        if (exp_we) begin
            check({name, " we addr"}, 32'(we_addr), 32'(exp_addr));
            check({name, " we data"}, 32'(we_data), 32'(exp_wdata));
        end
        if (exp_re) check({name, " re addr"}, 32'(re_addr), 32'(exp_addr));
    endtask

    typedef struct {
        int              n;
        logic [0:3][7:0] b;
        bit              we;
        bit              re;
        logic [15:0]     addr;
        logic [7:0]      wdata;
        logic [7:0]      reply;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int we0, tx0, found;

        vecs[0] = '{n:4, b:{8'h57, 8'h12, 8'h34, 8'hA5}, we:1'b1, re:1'b0, addr:16'h1234, wdata:8'hA5, reply:8'h4B};
        vecs[1] = '{n:3, b:{8'h52, 8'h12, 8'h34, 8'h00}, we:1'b0, re:1'b1, addr:16'h1234, wdata:8'h00, reply:8'hA5};
        vecs[2] = '{n:1, b:{8'h41, 8'h00, 8'h00, 8'h00}, we:1'b0, re:1'b0, addr:16'h0000, wdata:8'h00, reply:8'h3F};
        vecs[3] = '{n:4, b:{8'h57, 8'hFF, 8'hFF, 8'h00}, we:1'b1, re:1'b0, addr:16'hFFFF, wdata:8'h00, reply:8'h4B};
        vecs[4] = '{n:3, b:{8'h52, 8'hFF, 8'hFF, 8'h00}, we:1'b0, re:1'b1, addr:16'hFFFF, wdata:8'h00, reply:8'h00};
        vecs[5] = '{n:3, b:{8'h52, 8'hAB, 8'hCD, 8'h00}, we:1'b0, re:1'b1, addr:16'hABCD, wdata:8'h00, reply:8'h3C};
        vecs[6] = '{n:1, b:{8'h00, 8'h00, 8'h00, 8'h00}, we:1'b0, re:1'b0, addr:16'h0000, wdata:8'h00, reply:8'h3F};
        vecs[7] = '{n:3, b:{8'h52, 8'h00, 8'h00, 8'h00}, we:1'b0, re:1'b1, addr:16'h0000, wdata:8'h00, reply:8'h5A};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset tx_byte", 32'(tx_byte), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset strobes", 32'({mem_we, mem_re}), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Directed command table
        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].n, vecs[i].b, vecs[i].we, vecs[i].re,
                    vecs[i].addr, vecs[i].wdata, vecs[i].reply, 1);
            if (vecs[i].we) ref_mem[int'(vecs[i].addr)] = vecs[i].wdata;
        end

        // Reply waits while the transmitter is busy
        tx_force = 1'b1;
        @(negedge clk);
        tx0 = tx_n;
        send_byte(8'h41);
        repeat (6) @(negedge clk);
        check("send waits tx count", 32'(tx_n - tx0), 32'd0);
        check("send waits busy", 32'(busy), 32'd1);
        tx_force = 1'b0;
        wait_idle("send waits");
        check("send waits tx after", 32'(tx_n - tx0), 32'd1);
        check("send waits reply", 32'(tx_seen), 32'h3F);

        // Partial command abandoned after TO silent cycles
        we0 = we_n; tx0 = tx_n;
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (TO - 1) @(negedge clk);
        check("timeout busy before expiry", 32'(busy), 32'd1);
        @(negedge clk);
        check("timeout busy after expiry", 32'(busy), 32'd0);
        check("timeout no we", 32'(we_n - we0), 32'd0);
        check("timeout no tx", 32'(tx_n - tx0), 32'd0);
        run_cmd("after timeout", 3, {8'h52, 8'h12, 8'h34, 8'h00}, 1'b0, 1'b1, 16'h1234, 8'h00,
                ref_read(16'h1234), 1);

        // Byte on the expiry cycle is still accepted
        we0 = we_n;
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h34);
        send_byte(8'hC3);
        wait_idle("expiry accept");
        check("expiry accept we", 32'(we_n - we0), 32'd1);
        check("expiry accept addr", 32'(we_addr), 32'h1234);
        check("expiry accept data", 32'(we_data), 32'hC3);
        check("expiry accept reply", 32'(tx_seen), 32'h4B);
        ref_mem[int'(16'h1234)] = 8'hC3;

        // One cycle later the command is gone and the byte is an unknown command
        we0 = we_n; tx0 = tx_n;
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (TO) @(negedge clk);
        send_byte(8'h34);
        wait_idle("late byte");
        check("late byte no we", 32'(we_n - we0), 32'd0);
        check("late byte reply", 32'(tx_seen), 32'h3F);
        check("late byte tx count", 32'(tx_n - tx0), 32'd1);

        // Byte arriving during HOLD with the transmitter busy
        check("overrun clear before", 32'(overrun), 32'd0);
        tx_len = 8;
        tx0 = tx_n;
        send_byte(8'h41);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (tx_start) found = 1;
        end
        check("overrun tx_start seen", 32'(found), 32'd1);
        send_byte(8'h57);
        check("overrun set", 32'(overrun), 32'd1);
        wait_idle("overrun reply");
        check("overrun reply", 32'(tx_seen), 32'h3F);
        check("overrun tx count", 32'(tx_n - tx0), 32'd1);
        run_cmd("after overrun", 3, {8'h52, 8'h12, 8'h34, 8'h00}, 1'b0, 1'b1, 16'h1234, 8'h00,
                ref_read(16'h1234), 1);
        check("overrun sticky", 32'(overrun), 32'd1);
        tx_len = 3;

        // Reset in DATA abandons the write
        we0 = we_n; tx0 = tx_n;
        send_byte(8'h57);
        send_byte(8'h55);
        send_byte(8'h66);
        #2 rst = 1'b1;
        #1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst overrun", 32'(overrun), 32'd0);
        check("mid rst tx", 32'({tx_start, tx_byte}), 32'd0);
        check("mid rst mem_addr", 32'(mem_addr), 32'd0);
        check("mid rst mem_wdata", 32'(mem_wdata), 32'd0);
        check("mid rst strobes", 32'({mem_we, mem_re}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_cmd("first after rst", 3, {8'h52, 8'h56, 8'h78, 8'h00}, 1'b0, 1'b1, 16'h5678, 8'h00,
                ref_read(16'h5678), 0);
        check("aborted write absent", 32'(we_n - we0), 32'd0);
        run_cmd("aborted addr intact", 3, {8'h52, 8'h55, 8'h66, 8'h00}, 1'b0, 1'b1, 16'h5566, 8'h00,
                ref_read(16'h5566), 1);

        // Random commands against the reference model
        for (int k = 0; k < 40; k++) begin
            int          kind, gap;
            logic [15:0] a;
            logic [7:0]  d;
            kind   = $urandom_range(0, 2);
            gap    = $urandom_range(0, 3);
            tx_len = $urandom_range(0, 6);
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0010 + 16'($urandom_range(0, 3));
            d = 8'($urandom);
            if (kind == 0) begin
                run_cmd("rand wr", 4, {8'h57, a[15:8], a[7:0], d}, 1'b1, 1'b0, a, d, 8'h4B, gap);
                ref_mem[int'(a)] = d;
            end else if (kind == 1) begin
                run_cmd("rand rd", 3, {8'h52, a[15:8], a[7:0], 8'h00}, 1'b0, 1'b1, a, 8'h00, ref_read(a), gap);
            end else begin
                if (d == 8'h57 || d == 8'h52) d = 8'h00;
                run_cmd("rand bad", 1, {d, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h3F, gap);
            end
        end

        check("we and re never together", 32'(both_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 120000, idle clock cycles after which a partial command is abandoned.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  one-cycle pulse, byte available from UART receiver.
REQ-006 SHALL have port rx_byte  input  8  received byte, valid while rx_valid=1.
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-008 SHALL have port tx_start  output  1  one-cycle pulse requesting transmission of tx_byte.
REQ-009 SHALL have port tx_byte  output  8  reply byte; held stable from tx_start until the next tx_start.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  memory address.
REQ-011 SHALL have port mem_wdata  output  8  memory write data.
REQ-012 SHALL have port mem_we  output  1  one-cycle memory write strobe.
REQ-013 SHALL have port mem_re  output  1  one-cycle memory read strobe.
REQ-014 SHALL have port mem_rdata  input  8  read data, valid exactly one cycle after mem_re.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port overrun  output  1  sticky flag, byte dropped.

Function
REQ-017 SHALL implement states IDLE, ADDR_HI, ADDR_LO, DATA, RD_REQ, RD_WAIT, SEND, HOLD.
REQ-018 IDLE, rx_valid with rx_byte 0x57 ('W') or 0x52 ('R'): latch command, go ADDR_HI; any other byte: tx_byte=0x3F ('?'), go SEND.
REQ-019 ADDR_HI, rx_valid: address bits [15:8] = rx_byte, go ADDR_LO; for ADDR_WIDTH<16 excess bits discarded, for ADDR_WIDTH>16 upper bits zero.
REQ-020 ADDR_LO, rx_valid: address bits [7:0] = rx_byte; 'W' goes DATA, 'R' goes RD_REQ.
REQ-021 DATA, rx_valid: mem_wdata=rx_byte, mem_we=1 for exactly the next cycle, tx_byte=0x4B ('K'), go SEND.
REQ-022 RD_REQ: mem_re=1 for one cycle, go RD_WAIT; RD_WAIT: tx_byte=mem_rdata, go SEND.
REQ-023 mem_addr SHALL hold the assembled address from ADDR_LO completion until the next command's ADDR_HI byte.
REQ-024 SEND: wait for tx_busy=0, then pulse tx_start one cycle, go HOLD.
REQ-025 HOLD: ignore tx_busy in first HOLD cycle; afterwards go IDLE on tx_busy=0.
REQ-026 rx_valid in RD_REQ, RD_WAIT, SEND or HOLD: byte dropped, overrun set to 1; state unaffected.
REQ-027 Timeout counter SHALL clear on every accepted byte and count cycles in ADDR_HI, ADDR_LO, DATA; reaching TIMEOUT returns to IDLE with no memory access and no reply.
REQ-028 rx_valid in the same cycle as timeout expiry: byte accepted, timeout ignored.
REQ-029 Counter width SHALL be sufficient for TIMEOUT without wrap; overrun cleared only by rst.
REQ-030 mem_we and mem_re SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, tx_start=0, mem_we=0, mem_re=0, busy=0, overrun=0, tx_byte=0, mem_addr=0, mem_wdata=0, timeout counter=0.
REQ-032 rst asserted mid-command or mid-reply SHALL abandon it; no pending strobe issued after release.
REQ-033 First command SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-034 Bytes 0x57,0x12,0x34,0xA5 -> one mem_we with mem_addr=0x1234, mem_wdata=0xA5; then one tx_start with tx_byte=0x4B.
REQ-035 Bytes 0x52,0x12,0x34, mem_rdata=0xA5 after mem_re -> mem_re once at 0x1234; tx_start with tx_byte=0xA5.
REQ-036 Byte 0x41 in IDLE -> tx_start with tx_byte=0x3F, no memory strobe, busy back to 0 after tx_busy falls.
REQ-037 Bytes 0x57,0x00 then silence for TIMEOUT cycles -> busy=0, no mem_we, no tx_start; next 0x52 starts new command.
REQ-038 Byte arriving during HOLD with tx_busy=1 -> overrun=1, reply unaffected, overrun stays 1 until rst.
REQ-039 rst pulsed in DATA state -> busy=0, all outputs at reset values, no mem_we ever for the aborted command.
